axi_lite_arb2: RTL and testbench
================================

# axi_lite_arb2

Two-master AXI4-Lite arbiter. It lets two CPU-side master ports (m0, m1) share one AXI4-Lite slave port (s), which connects to the existing slave write/read engine in front of memory. Write (AW/W/B) and read (AR/R) paths are arbitrated independently, and each has its own grant FSM. A grant is held from address acceptance until the response handshake, so exactly one transaction per direction is outstanding.

## Interface
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- mN_awvalid/mN_awready (N=0,1)  in/out  1  master N write-address handshake
- mN_awaddr  in  ADDR_W  master N write address
- mN_wvalid/mN_wready  in/out  1  master N write-data handshake
- mN_wdata  in  DATA_W; mN_wstrb  in  DATA_W/8  master N write data and strobes
- mN_bvalid/mN_bready  out/in  1  master N write-response handshake; mN_bresp  out  2
- mN_arvalid/mN_arready  in/out  1  master N read-address handshake; mN_araddr  in  ADDR_W
- mN_rvalid/mN_rready  out/in  1  master N read-data handshake; mN_rdata  out  DATA_W; mN_rresp  out  2
- s_awvalid/s_awready, s_awaddr, s_wvalid/s_wready, s_wdata, s_wstrb  out/in  slave write-address and write-data channels
- s_bvalid/s_bready, s_bresp  in/out/in  slave write-response channel
- s_arvalid/s_arready, s_araddr, s_rvalid/s_rready, s_rdata, s_rresp  slave read channels
- Directions on s_* mirror a master port.

## Operation
- Write FSM states: W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: a master requests by asserting mN_awvalid. If any request is present, register the grant wgnt and go to W_ADDR. Otherwise stay.
  - W_ADDR: s_aw* and s_w* are muxed from the granted master. mN_awready and mN_wready come from s_*ready for the granted master and are 0 for the other master.
  - Flags aw_done and w_done record each handshake. AW and W may complete in either order or in the same cycle. Once both are done (registered or current cycle), go to W_RESP.
  - W_RESP: s_bvalid and s_bresp route to the granted master, and s_bready comes from that master. On the B handshake, go to W_IDLE, clear the flags and update the last-grant pointer.
- Read FSM states: R_IDLE, R_ADDR, R_RESP. Same scheme on mN_arvalid: the AR handshake moves R_ADDR to R_RESP, and the R handshake moves R_RESP to R_IDLE.
- Arbitration with two simultaneous requests follows the policy set under Configuration.
- The non-granted master sees all ready and valid outputs at 0. Its valid and payload are ignored and held by AXI rules.
- Slave-side valids are 0 in IDLE and in RESP. s_bready and s_rready are 0 outside RESP.
- Write and read FSMs may grant different masters concurrently.

## Timing
- Reset values:
  - All mN_*ready, mN_bvalid, mN_rvalid, s_*valid, s_bready and s_rready are 0.
  - Payload outputs are 0.
  - FSMs are in IDLE, flags are clear, and both last-grant pointers = 1, so m0 wins the first tie.
- Arbitration latency: a request seen in IDLE at cycle N gives a registered grant, and s_awvalid/s_arvalid assert in cycle N+1.
- After grant, the address, data, ready and response paths are combinational pass-through with no added cycles.
- After a response handshake in cycle N, the FSM is in IDLE at N+1 and the next grant is at N+2. There is one bubble cycle between back-to-back transactions.
- A request that drops before grant is not legal AXI and is not supported. The grant is registered in the IDLE cycle, so the FSM commits to that master.
- Reset asserted mid-transaction: return immediately to reset values. In-flight handshakes are abandoned, and the bench reissues them after reset.

## Configuration
- AXI_ARB_RR_EN defined: round-robin. On a tie, the master not granted last wins. The pointer updates only on the response handshake.
- AXI_ARB_RR_EN undefined: fixed priority, so m0 always wins a tie. The pointer logic is compiled out.

## Structure
- Package axi_arb_pkg holds:
  - the write and read FSM state typedefs;
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the master-index typedef.
- One sub-module, axi_arb_pick. It is a 2-requester picker (req[1:0], last, update → gnt) with the round-robin pointer under AXI_ARB_RR_EN. It is instantiated twice, once for writes and once for reads.

## Test plan
- m0 writes addr 0x10, data 0xA5A5A5A5, strb 0xF, with AW before W → s_awaddr=0x10 one cycle after the request, m0_bresp=OKAY, and m1 sees no ready.
- m0 and m1 raise awvalid in the same cycle, three times in a row:
  - with RR: grants are m0, m1, m0;
  - without AXI_ARB_RR_EN: grants are m0, m0, m0.
- m1 sends W two cycles before AW, and the slave holds s_awready low for three cycles → transfer completes and data 0x12345678 reaches the slave.
- m0 write and m1 read of 0x20 issued concurrently → both complete independently, and m1_rdata equals the slave's rdata (0xDEADBEEF).
- The slave returns SLVERR on a read → m0_rresp=2'b10 is passed through unmodified.
- rst is asserted while in W_RESP → all outputs are 0 in the same cycle, and the write FSM is in W_IDLE afterward.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  typedef enum logic {
    MST0 = 1'b0,
    MST1 = 1'b1
  } mst_idx_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_arb_pick.sv
// Two-requester picker. Round-robin when AXI_ARB_RR_EN is defined, else fixed priority (m0 wins).
module axi_arb_pick
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  mst_idx_e   last,
  input  logic       update,
  output mst_idx_e   gnt
);

`ifdef AXI_ARB_RR_EN
  mst_idx_e ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= MST1;
    else if (update) ptr <= last;
  end

  // On a tie the master that was not served last wins.
  always_comb begin
    gnt = MST0;
    case (req)
      2'b10:   gnt = MST1;
      2'b11:   gnt = (ptr == MST0) ? MST1 : MST0;
      default: gnt = MST0;
    endcase
  end
`else
  assign gnt = (req == 2'b10) ? MST1 : MST0;

  logic unused_rr;
  assign unused_rr = ^{clk, rst, last, update};
`endif

endmodule

// File: rtl/axi_lite_arb2.sv
// Two-master AXI4-Lite arbiter with independent write and read grant FSMs.
// Tie policy selected by AXI_ARB_RR_EN (round-robin) or fixed priority when undefined.
module axi_lite_arb2
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // master 0
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  output logic [1:0]          m0_bresp,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  // master 1
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  // slave
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp
);

  w_state_e w_state, w_state_nxt;
  r_state_e r_state, r_state_nxt;
  mst_idx_e wgnt, wgnt_nxt, w_pick;
  mst_idx_e rgnt, rgnt_nxt, r_pick;
  logic     aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic     w_upd, r_upd;
  logic     aw_hs, w_hs, b_hs, ar_hs, r_hs;

  axi_arb_pick u_wpick (
    .clk    (clk),
    .rst    (rst),
    .req    ({m1_awvalid, m0_awvalid}),
    .last   (wgnt),
    .update (w_upd),
    .gnt    (w_pick)
  );

  axi_arb_pick u_rpick (
    .clk    (clk),
    .rst    (rst),
    .req    ({m1_arvalid, m0_arvalid}),
    .last   (rgnt),
    .update (r_upd),
    .gnt    (r_pick)
  );

  // Phase decodes and granted-master selects
  logic w_addr_ph, w_resp_ph, r_addr_ph, r_resp_ph;
  logic wg1, rg1;
  assign w_addr_ph = (w_state == W_ADDR);
  assign w_resp_ph = (w_state == W_RESP);
  assign r_addr_ph = (r_state == R_ADDR);
  assign r_resp_ph = (r_state == R_RESP);
  assign wg1       = (wgnt == MST1);
  assign rg1       = (rgnt == MST1);

  // Write path: slave side
  assign s_awvalid = w_addr_ph & ~aw_done & (wg1 ? m1_awvalid : m0_awvalid);
  assign s_awaddr  = w_addr_ph ? (wg1 ? m1_awaddr : m0_awaddr) : '0;
  assign s_wvalid  = w_addr_ph & ~w_done & (wg1 ? m1_wvalid : m0_wvalid);
  assign s_wdata   = w_addr_ph ? (wg1 ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb   = w_addr_ph ? (wg1 ? m1_wstrb : m0_wstrb) : '0;
  assign s_bready  = w_resp_ph & (wg1 ? m1_bready : m0_bready);

  // Write path: master side
  assign m0_awready = w_addr_ph & ~aw_done & ~wg1 & s_awready;
  assign m1_awready = w_addr_ph & ~aw_done &  wg1 & s_awready;
  assign m0_wready  = w_addr_ph & ~w_done  & ~wg1 & s_wready;
  assign m1_wready  = w_addr_ph & ~w_done  &  wg1 & s_wready;
  assign m0_bvalid  = w_resp_ph & ~wg1 & s_bvalid;
  assign m1_bvalid  = w_resp_ph &  wg1 & s_bvalid;
  assign m0_bresp   = (w_resp_ph & ~wg1) ? s_bresp : RESP_OKAY;
  assign m1_bresp   = (w_resp_ph &  wg1) ? s_bresp : RESP_OKAY;

  // Read path
  assign s_arvalid  = r_addr_ph & (rg1 ? m1_arvalid : m0_arvalid);
  assign s_araddr   = r_addr_ph ? (rg1 ? m1_araddr : m0_araddr) : '0;
  assign s_rready   = r_resp_ph & (rg1 ? m1_rready : m0_rready);
  assign m0_arready = r_addr_ph & ~rg1 & s_arready;
  assign m1_arready = r_addr_ph &  rg1 & s_arready;
  assign m0_rvalid  = r_resp_ph & ~rg1 & s_rvalid;
  assign m1_rvalid  = r_resp_ph &  rg1 & s_rvalid;
  assign m0_rdata   = (r_resp_ph & ~rg1) ? s_rdata : '0;
  assign m1_rdata   = (r_resp_ph &  rg1) ? s_rdata : '0;
  assign m0_rresp   = (r_resp_ph & ~rg1) ? s_rresp : RESP_OKAY;
  assign m1_rresp   = (r_resp_ph &  rg1) ? s_rresp : RESP_OKAY;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = w_state;
    wgnt_nxt    = wgnt;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    w_upd       = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (m0_awvalid | m1_awvalid) begin
          wgnt_nxt    = w_pick;
          w_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if (aw_done_nxt && w_done_nxt) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_nxt = W_IDLE;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          w_upd       = 1'b1;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    rgnt_nxt    = rgnt;
    r_upd       = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (m0_arvalid | m1_arvalid) begin
          rgnt_nxt    = r_pick;
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: if (ar_hs) r_state_nxt = R_RESP;
      R_RESP: begin
        if (r_hs) begin
          r_state_nxt = R_IDLE;
          r_upd       = 1'b1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      wgnt    <= MST0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      r_state <= R_IDLE;
      rgnt    <= MST0;
    end else begin
      w_state <= w_state_nxt;
      wgnt    <= wgnt_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      r_state <= r_state_nxt;
      rgnt    <= rgnt_nxt;
    end
  end

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2 with a behavioural slave and write/read scoreboards.
module tb_axi_lite_arb2;
  import axi_arb_pkg::*;

  localparam int BUDGET = 60;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } wr_item_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_awvalid [2];
  logic        m_awready [2];
  logic [31:0] m_awaddr  [2];
  logic        m_wvalid  [2];
  logic        m_wready  [2];
  logic [31:0] m_wdata   [2];
  logic [3:0]  m_wstrb   [2];
  logic        m_bvalid  [2];
  logic        m_bready  [2];
  logic [1:0]  m_bresp   [2];
  logic        m_arvalid [2];
  logic        m_arready [2];
  logic [31:0] m_araddr  [2];
  logic        m_rvalid  [2];
  logic        m_rready  [2];
  logic [31:0] m_rdata   [2];
  logic [1:0]  m_rresp   [2];

  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;

  axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awaddr(m_awaddr[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]), .m0_bresp(m_bresp[0]),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_araddr(m_araddr[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awaddr(m_awaddr[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]), .m1_bresp(m_bresp[1]),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_araddr(m_araddr[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  // Every DUT output in one vector, used by the reset checks
  logic [255:0] out_bus;
  assign out_bus = 256'({
    m_awready[0], m_wready[0], m_bvalid[0], m_bresp[0], m_arready[0], m_rvalid[0], m_rdata[0], m_rresp[0],
    m_awready[1], m_wready[1], m_bvalid[1], m_bresp[1], m_arready[1], m_rvalid[1], m_rdata[1], m_rresp[1],
    s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready, s_arvalid, s_araddr, s_rready});

  int vectors = 0;
  int miscompares = 0;

  wr_item_t sb_wr[$];
  rd_item_t sb_rd_slv[$];
  rd_item_t sb_rd_exp[$];
  int aw_stall_cfg = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave: write side ----------------
  initial begin : slave_wr
    bit got_aw = 0, got_w = 0, b_fin = 0;
    int aw_wait = 0;
    logic [31:0] cap_a = '0, cap_d = '0;
    logic [3:0]  cap_s = '0;
    wr_item_t it;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    forever begin
      @(negedge clk);
      b_fin = 0;
      if (!rst) begin
        if (s_awvalid && s_awready) begin got_aw = 1; cap_a = s_awaddr; end
        else if (s_awvalid) aw_wait++;
        if (s_wvalid && s_wready) begin got_w = 1; cap_d = s_wdata; cap_s = s_wstrb; end
        b_fin = s_bvalid && s_bready;
      end
      @(posedge clk); #1;
      if (rst) begin
        got_aw = 0; got_w = 0; aw_wait = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
      end else begin
        if (b_fin) begin s_bvalid = 0; got_aw = 0; got_w = 0; aw_wait = 0; end
        s_awready = !got_aw && (aw_wait >= aw_stall_cfg);
        s_wready  = !got_w;
        if (got_aw && got_w && !s_bvalid) begin
          check("sb_wr_nonempty", 256'(sb_wr.size() > 0), 256'(1));
          if (sb_wr.size() > 0) begin
            it = sb_wr.pop_front();
            check("slv_awaddr", cap_a, it.addr);
            check("slv_wdata", cap_d, it.data);
            check("slv_wstrb", cap_s, it.strb);
            s_bresp = it.resp;
          end
          s_bvalid = 1;
        end
      end
    end
  end

  // ---------------- behavioural slave: read side ----------------
  initial begin : slave_rd
    bit got_ar = 0, r_fin = 0;
    logic [31:0] cap_a = '0;
    rd_item_t it;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    forever begin
      @(negedge clk);
      r_fin = 0;
      if (!rst) begin
        if (s_arvalid && s_arready) begin got_ar = 1; cap_a = s_araddr; end
        r_fin = s_rvalid && s_rready;
      end
      @(posedge clk); #1;
      if (rst) begin
        got_ar = 0; s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
      end else begin
        if (r_fin) begin s_rvalid = 0; got_ar = 0; end
        s_arready = !got_ar;
        if (got_ar && !s_rvalid) begin
          check("sb_rd_nonempty", 256'(sb_rd_slv.size() > 0), 256'(1));
          if (sb_rd_slv.size() > 0) begin
            it = sb_rd_slv.pop_front();
            check("slv_araddr", cap_a, it.addr);
            s_rdata = it.data;
            s_rresp = it.resp;
          end
          s_rvalid = 1;
        end
      end
    end
  end

  // ---------------- master-side tasks (start and end at posedge+1) ----------------
  task automatic drive_aw(input int n, input logic [31:0] a, input int dly);
    bit hs = 0;
    repeat (dly) begin @(posedge clk); #1; end
    m_awvalid[n] = 1; m_awaddr[n] = a;
    for (int k = 0; k < BUDGET && !hs; k++) begin @(negedge clk); hs = m_awready[n]; end
    if (!hs) check($sformatf("aw_timeout_m%0d", n), 256'(hs), 256'(1));
    @(posedge clk); #1;
    m_awvalid[n] = 0;
  endtask

  task automatic drive_w(input int n, input logic [31:0] d, input logic [3:0] s, input int dly);
    bit hs = 0;
    repeat (dly) begin @(posedge clk); #1; end
    m_wvalid[n] = 1; m_wdata[n] = d; m_wstrb[n] = s;
    for (int k = 0; k < BUDGET && !hs; k++) begin @(negedge clk); hs = m_wready[n]; end
    if (!hs) check($sformatf("w_timeout_m%0d", n), 256'(hs), 256'(1));
    @(posedge clk); #1;
    m_wvalid[n] = 0;
  endtask

  task automatic m_write(input int n, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int aw_dly, input int w_dly,
                         input logic [1:0] exp_resp);
    bit hs = 0;
    logic [1:0] resp = 2'bxx;
    m_bready[n] = 1;
    fork
      drive_aw(n, a, aw_dly);
      drive_w(n, d, s, w_dly);
    join
    for (int k = 0; k < BUDGET && !hs; k++) begin
      @(negedge clk);
      hs = m_bvalid[n];
      if (hs) resp = m_bresp[n];
    end
    if (!hs) check($sformatf("b_timeout_m%0d", n), 256'(hs), 256'(1));
    @(posedge clk); #1;
    m_bready[n] = 0;
    check($sformatf("m%0d_bresp", n), resp, exp_resp);
  endtask

  task automatic m_read(input int n, input logic [31:0] a);
    bit hs = 0;
    logic [31:0] data = 'x;
    logic [1:0]  resp = 'x;
    rd_item_t    it;
    m_rready[n] = 1; m_arvalid[n] = 1; m_araddr[n] = a;
    for (int k = 0; k < BUDGET && !hs; k++) begin @(negedge clk); hs = m_arready[n]; end
    if (!hs) check($sformatf("ar_timeout_m%0d", n), 256'(hs), 256'(1));
    @(posedge clk); #1;
    m_arvalid[n] = 0;
    hs = 0;
    for (int k = 0; k < BUDGET && !hs; k++) begin
      @(negedge clk);
      hs = m_rvalid[n];
      if (hs) begin data = m_rdata[n]; resp = m_rresp[n]; end
    end
    if (!hs) check($sformatf("r_timeout_m%0d", n), 256'(hs), 256'(1));
    @(posedge clk); #1;
    m_rready[n] = 0;
    check("sb_rd_exp_nonempty", 256'(sb_rd_exp.size() > 0), 256'(1));
    if (sb_rd_exp.size() > 0) begin
      it = sb_rd_exp.pop_front();
      check($sformatf("m%0d_rdata", n), data, it.data);
      check($sformatf("m%0d_rresp", n), resp, it.resp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] r);
    wr_item_t it;
    it.addr = a; it.data = d; it.strb = s; it.resp = r;
    sb_wr.push_back(it);
  endtask

  task automatic push_rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    rd_item_t it;
    it.addr = a; it.data = d; it.resp = r;
    sb_rd_slv.push_back(it);
    sb_rd_exp.push_back(it);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    bit hs;
    for (int i = 0; i < 2; i++) begin
      m_awvalid[i] = 1; m_awaddr[i] = 32'hFFFF_0000 | i; m_wvalid[i] = 1;
      m_wdata[i] = 32'h5555_AAAA; m_wstrb[i] = 4'hF; m_bready[i] = 1;
      m_arvalid[i] = 1; m_araddr[i] = 32'h0000_FFFF; m_rready[i] = 1;
    end

    // Reset values with active requests present
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", out_bus, '0);
    check("reset_w_state", 256'(dut.w_state), 256'(W_IDLE));
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      m_awvalid[i] = 0; m_awaddr[i] = 0; m_wvalid[i] = 0; m_wdata[i] = 0; m_wstrb[i] = 0;
      m_bready[i] = 0; m_arvalid[i] = 0; m_araddr[i] = 0; m_rready[i] = 0;
    end
    @(posedge clk); #1;
    rst = 0;
    repeat (2) begin @(posedge clk); #1; end

    // m0 single write, AW before W; grant latency and isolation of m1
    push_wr(32'h10, 32'hA5A5_A5A5, 4'hF, RESP_OKAY);
    fork
      m_write(0, 32'h10, 32'hA5A5_A5A5, 4'hF, 0, 1, RESP_OKAY);
      begin
        @(negedge clk);
        check("grant_cycle_awvalid", 256'(s_awvalid), 256'(0));
        @(negedge clk);
        check("post_grant_awvalid", 256'(s_awvalid), 256'(1));
        check("post_grant_awaddr", s_awaddr, 32'h10);
        check("m0_awready", 256'(m_awready[0]), 256'(1));
        check("m1_awready_idle", 256'(m_awready[1]), 256'(0));
        check("m1_wready_idle", 256'(m_wready[1]), 256'(0));
      end
    join
    repeat (2) begin @(posedge clk); #1; end

    // Simultaneous requests from both masters, each issuing three writes back-to-back
`ifdef AXI_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      push_wr(32'h100 + 4 * i, 32'h0A00_0000 + i, 4'hF, RESP_OKAY);
      push_wr(32'h200 + 4 * i, 32'h0B00_0000 + i, 4'hF, RESP_OKAY);
    end
`else
    for (int i = 0; i < 3; i++) push_wr(32'h100 + 4 * i, 32'h0A00_0000 + i, 4'hF, RESP_OKAY);
    for (int i = 0; i < 3; i++) push_wr(32'h200 + 4 * i, 32'h0B00_0000 + i, 4'hF, RESP_OKAY);
`endif
    fork
      for (int i = 0; i < 3; i++) m_write(0, 32'h100 + 4 * i, 32'h0A00_0000 + i, 4'hF, 0, 0, RESP_OKAY);
      for (int j = 0; j < 3; j++) m_write(1, 32'h200 + 4 * j, 32'h0B00_0000 + j, 4'hF, 0, 0, RESP_OKAY);
    join
    repeat (2) begin @(posedge clk); #1; end

    // m1 W two cycles before AW, slave stalls AW for three cycles
    aw_stall_cfg = 3;
    push_wr(32'h34, 32'h1234_5678, 4'hC, RESP_OKAY);
    m_write(1, 32'h34, 32'h1234_5678, 4'hC, 2, 0, RESP_OKAY);
    aw_stall_cfg = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Slave error response on a write routes back unmodified
    push_wr(32'h70, 32'h0000_0070, 4'h1, RESP_SLVERR);
    m_write(1, 32'h70, 32'h0000_0070, 4'h1, 0, 0, RESP_SLVERR);
    repeat (2) begin @(posedge clk); #1; end

    // Concurrent m0 write and m1 read
    push_wr(32'h40, 32'hCAFE_F00D, 4'hF, RESP_OKAY);
    push_rd(32'h20, 32'hDEAD_BEEF, RESP_OKAY);
    fork
      m_write(0, 32'h40, 32'hCAFE_F00D, 4'hF, 0, 0, RESP_OKAY);
      m_read(1, 32'h20);
    join
    repeat (2) begin @(posedge clk); #1; end

    // Read with SLVERR
    push_rd(32'h30, 32'h0BAD_F00D, RESP_SLVERR);
    m_read(0, 32'h30);
    repeat (2) begin @(posedge clk); #1; end

    // Reset while waiting in W_RESP
    push_wr(32'h50, 32'h5050_5050, 4'hF, RESP_OKAY);
    m_bready[0] = 0;
    fork
      drive_aw(0, 32'h50, 0);
      drive_w(0, 32'h5050_5050, 4'hF, 0);
    join
    hs = 0;
    for (int k = 0; k < BUDGET && !hs; k++) begin @(negedge clk); hs = m_bvalid[0]; end
    check("resp_wait_bvalid", 256'(hs), 256'(1));
    rst = 1;
    #1;
    check("midrst_outputs_zero", out_bus, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("post_rst_w_state", 256'(dut.w_state), 256'(W_IDLE));
    @(posedge clk); #1;

    // Reissue the abandoned write
    push_wr(32'h50, 32'h5050_5050, 4'hF, RESP_OKAY);
    m_write(0, 32'h50, 32'h5050_5050, 4'hF, 0, 0, RESP_OKAY);
    repeat (3) begin @(posedge clk); #1; end

    check("sb_wr_drained", 256'(sb_wr.size()), 256'(0));
    check("sb_rd_drained", 256'(sb_rd_exp.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
